// File: rtl/byte_serial_adder_pkg.sv
// rtl/byte_serial_adder_pkg.sv - shared constants, FSM states and helpers for the byte-serial adder
package byte_serial_adder_pkg;

    localparam int BYTE_W   = 8;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_add_cin.sv
// rtl/byte_add_cin.sv - 8-bit carry-select adder with carry-in, exports carry into bit 7
module byte_add_cin
    import byte_serial_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_sum,
    output logic              o_cout,
    output logic              o_c7
);

    logic [NIBBLE_W-1:0] w_lo_sum;
    logic                w_lo_cout;
    logic [NIBBLE_W-1:0] w_hi0_sum;
    logic                w_hi0_cout;
    logic [NIBBLE_W-1:0] w_hi1_sum;
    logic                w_hi1_cout;
    logic [NIBBLE_W:0]   w_hi_sel;

    ripple_carry_adder #(.WIDTH(NIBBLE_W)) u_lo (
        .i_a    (i_a[NIBBLE_W-1:0]),
        .i_b    (i_b[NIBBLE_W-1:0]),
        .i_cin  (i_cin),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    // Both high-nibble results are precomputed; the low-nibble carry picks one.
    ripple_carry_adder #(.WIDTH(NIBBLE_W)) u_hi0 (
        .i_a    (i_a[BYTE_W-1:NIBBLE_W]),
        .i_b    (i_b[BYTE_W-1:NIBBLE_W]),
        .i_cin  (1'b0),
        .o_sum  (w_hi0_sum),
        .o_cout (w_hi0_cout)
    );

    ripple_carry_adder #(.WIDTH(NIBBLE_W)) u_hi1 (
        .i_a    (i_a[BYTE_W-1:NIBBLE_W]),
        .i_b    (i_b[BYTE_W-1:NIBBLE_W]),
        .i_cin  (1'b1),
        .o_sum  (w_hi1_sum),
        .o_cout (w_hi1_cout)
    );

    mux2 #(.WIDTH(NIBBLE_W + 1)) u_sel (
        .i_sel (w_lo_cout),
        .i_d0  ({w_hi0_cout, w_hi0_sum}),
        .i_d1  ({w_hi1_cout, w_hi1_sum}),
        .o_y   (w_hi_sel)
    );

    assign o_sum  = {w_hi_sel[NIBBLE_W-1:0], w_lo_sum};
    assign o_cout = w_hi_sel[NIBBLE_W];
    // Sum bit 7 is a^b^carry_in, so the carry into bit 7 falls out of it directly.
    assign o_c7   = o_sum[BYTE_W-1] ^ i_a[BYTE_W-1] ^ i_b[BYTE_W-1];

endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - parameterised 2:1 multiplexer
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - ripple-carry adder with carry-in, nibble wide by default
module ripple_carry_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - multi-byte adder reusing one 8-bit carry-select adder, one byte per clock
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NBYTES-1:0]    a,
    input  logic [8*NBYTES-1:0]    b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NBYTES-1:0]    sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = clog2(NBYTES);

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic [BYTE_W-1:0]  w_byte_a;
    logic [BYTE_W-1:0]  w_byte_b;
    logic [BYTE_W-1:0]  w_byte_sum;
    logic               w_byte_cout;
    logic               w_byte_c7;
    logic               w_last;

    assign w_byte_a = r_a[r_idx*BYTE_W +: BYTE_W];
    assign w_byte_b = r_b[r_idx*BYTE_W +: BYTE_W];
    assign w_last   = (r_idx == IDX_W'(NBYTES - 1));

    byte_add_cin u_byte_add (
        .i_a    (w_byte_a),
        .i_b    (w_byte_b),
        .i_cin  (r_carry),
        .o_sum  (w_byte_sum),
        .o_cout (w_byte_cout),
        .o_c7   (w_byte_c7)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx*BYTE_W +: BYTE_W] <= w_byte_sum;
                    r_carry                       <= w_byte_cout;
                    if (w_last) begin
                        r_cout <= w_byte_cout;
                        r_ovf  <= w_byte_c7 ^ w_byte_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
